decode_stage_pipe: RTL
======================

// Module: decode_stage_pipe
// PURPOSE
//  Registered decode stage: splits a fetched instruction into opcode/rd/rs/rt/imm, selects the true
//  second source register per opcode class, and stalls on load-use hazards via a small scoreboard.
//  Sits between the IF/ID latch and the register-file read / ID/EX latch.
//  Successor to combinational rs/rt decode: parametrised widths, valid/ready handshake, hazard stall, flush.
// PARAMETERS
//  INSN_W    32  instruction width; fields packed from MSB: opcode|rd|rs|rt, imm in the low IMM_W bits
//  OPC_W      5  opcode width
//  REG_W      5  register specifier width
//  IMM_W     17  immediate width (overlaps rt field)
//  DATA_W    32  sign-extended immediate output width
//  LOAD_LAT   2  cycles a load destination stays pending after issue (>=1)
// PORTS
//  clock      in   1        rising-edge clock
//  reset      in   1        synchronous, active-high
//  flush      in   1        kill the instruction held in the output register (branch/jump redirect)
//  in_valid   in   1        instruction present
//  in_ready   out  1        stage accepts instruction this cycle
//  in_insn    in   INSN_W   instruction word
//  out_valid  out  1        decoded fields valid
//  out_ready  in   1        downstream accepts
//  out_opcode out  OPC_W    = insn[INSN_W-1 -: OPC_W] (32b: [31:27])
//  out_rd     out  REG_W    = next REG_W bits (32b: [26:22])
//  out_rs     out  REG_W    = next REG_W bits (32b: [21:17])
//  out_rt     out  REG_W    rd field if rt_from_rd(opcode), else the rt field (32b: [16:12])
//  out_imm    out  DATA_W   insn[IMM_W-1:0] sign-extended
//  out_is_load out 1        opcode == OP_LW
//  hazard     out  1        combinational: load-use stall active this cycle
// BEHAVIOUR
//  Reset: out_valid=0, every out_* field=0, all scoreboard entries invalid. Combinational hazard is 0 once
//   reset is released.
//  rt_from_rd(opcode) true for opcodes 00001..00111, 01000, 10101, 10110; otherwise false.
//  Source use: rs always a source. rt is a source only when rt_from_rd is false, or the opcode is a store/branch
//   (SRC_RT_SET in pkg).
//  hazard = in_valid & any valid scoreboard entry with dest==rs or (rt is source & dest==rt); dest 0 never matches.
//  in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
//  in_fire = in_valid & in_ready -> output register loads decoded fields next edge, out_valid=1. Latency 1 cycle.
//  Output held stable while out_valid & ~out_ready. If out_ready & ~in_fire, out_valid clears next edge; a hazard
//   thus produces a bubble.
//  flush: out_valid clears next edge; input is not accepted that cycle. flush+reset: reset wins.
//  Scoreboard: LOAD_LAT-entry shift register of {v,dest}. It advances only when out_ready=1.
//   - A load is pushed {1,rd} at entry 0 on the edge where it leaves the output register (out_valid & out_ready).
//   - If the load is flushed, nothing is pushed.
//   - The oldest entry drops off. Flush does not clear the scoreboard, because the entries are older, issued loads.
//  Stall lasts until the matching entry shifts out. Back-to-back load->use gives exactly LOAD_LAT bubbles
//   when out_ready is held 1.
// STRUCTURE
//  isa_pkg: OPC_W/REG_W constants, OP_LW, OP_SW, branch opcodes, rt_from_rd() and src_rt() functions, field-offset
//   localparams.
//  One sub-module, load_scoreboard (shift/match, LOAD_LAT param). Field decode and the output register stay in
//   this top module.
// TESTING
//  1 Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, out_rt=0, hazard=0.
//  2 rt select:
//    - R-type 0x00000000|rd=3,rs=1,rt=2 -> out_rt=2.
//    - Opcode 00101, rd=7, rt field=2 -> out_rt=7.
//    - Opcode 10101 -> out_rt=rd; opcode 10100 -> out_rt=rt field.
//  3 Load-use: lw rd=4, then add rs=4, with out_ready=1 and LOAD_LAT=2 -> 2 bubbles, add emitted on the 3rd cycle.
//    Repeat with rs=0 -> no bubble.
//  4 Backpressure: out_ready=0 for 5 cycles with a valid output -> out fields stable, in_ready=0, scoreboard
//    frozen. Release -> resumes in order.
//  5 Flush: flush while a lw is held -> out_valid=0 next cycle, no scoreboard push, next use of that rd
//    proceeds without stall.
//  6 Imm: imm=0x10000 -> out_imm=0xFFFF0000; imm=0x0FFFF -> 0x0000FFFF.

Source files
------------

// File: rtl/decode_stage_pipe_pkg.sv
// Shared ISA definitions for the decode stage: field geometry, opcode
// encodings, second-source selection helpers and the load scoreboard entry.
// Imported by the interface, the top and the scoreboard.
package decode_stage_pipe_pkg;

  // Opcode and register fields define the ISA encoding, so their widths live here.
  localparam int OPC_W = 5;
  localparam int REG_W = 5;

  // Default datapath geometry.
  localparam int INSN_W_DEF   = 32;
  localparam int IMM_W_DEF    = 17;
  localparam int DATA_W_DEF   = 32;
  localparam int LOAD_LAT_DEF = 2;

  // Field offsets, counted down from the instruction MSB.
  localparam int RD_OFS = OPC_W;
  localparam int RS_OFS = OPC_W + REG_W;
  localparam int RT_OFS = OPC_W + 2 * REG_W;

  typedef logic [OPC_W-1:0] opc_t;
  typedef logic [REG_W-1:0] reg_t;

  localparam opc_t OP_LW  = 5'b00011;
  localparam opc_t OP_SW  = 5'b00100;
  localparam opc_t OP_BEQ = 5'b10101;
  localparam opc_t OP_BNE = 5'b10110;

  // One pending-load slot: valid bit and destination register.
  typedef struct packed {
    logic v;
    reg_t dest;
  } sb_ent_t;

  // Opcodes whose rt field carries immediate bits, so the second register is rd.
  function automatic logic rt_from_rd(input opc_t opc);
    return opc inside {[5'b00001:5'b01000], 5'b10101, 5'b10110};
  endfunction

  // Second register is read when it comes from the real rt field, or when
  // stores and branches read rd as data/comparand.
  function automatic logic src_rt(input opc_t opc);
    return !rt_from_rd(opc) || (opc inside {OP_SW, OP_BEQ, OP_BNE});
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Handshake bundle around the decode stage: instruction input side, decoded
// output side, flush and hazard. master = upstream/downstream environment,
// slave = the decode stage itself.
interface decode_stage_pipe_if
#(
  parameter int INSN_W = decode_stage_pipe_pkg::INSN_W_DEF,
  parameter int DATA_W = decode_stage_pipe_pkg::DATA_W_DEF
);
  import decode_stage_pipe_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [INSN_W-1:0] in_insn;
  logic              out_valid;
  logic              out_ready;
  opc_t              out_opcode;
  reg_t              out_rd;
  reg_t              out_rs;
  reg_t              out_rt;
  logic [DATA_W-1:0] out_imm;
  logic              out_is_load;
  logic              hazard;

  modport master (
    output flush, in_valid, in_insn, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt, out_imm,
           out_is_load, hazard
  );

  modport slave (
    input  flush, in_valid, in_insn, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt, out_imm,
           out_is_load, hazard
  );

endinterface

// File: rtl/decode_stage_pipe_load_scoreboard.sv
// Load-use scoreboard: shift register of issued load destinations, matched
// against the sources of the instruction waiting at the decode input.
// Ports: advance (downstream ready), push/push_dest (load leaving the stage),
// held (load sitting in the output register), req/rs/rt/rt_src (candidate), hazard.
module load_scoreboard
  import decode_stage_pipe_pkg::*;
#(
  parameter int LOAD_LAT = LOAD_LAT_DEF
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    advance,
  input  logic    push,
  input  reg_t    push_dest,
  input  sb_ent_t held,
  input  logic    req,
  input  reg_t    rs,
  input  reg_t    rt,
  input  logic    rt_src,
  output logic    hazard
);

  // A load already blocks while it waits in the output register; that slot is
  // the first of its LOAD_LAT pending cycles, so only LOAD_LAT-1 more are stored.
  localparam int DEPTH = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

  sb_ent_t ent [DEPTH];
  logic    pend;

  function automatic logic hit(input sb_ent_t e, input reg_t s1, input reg_t s2,
                               input logic s2_used);
    // r0 is hardwired, so a load targeting it never creates a dependency.
    return e.v && (e.dest != '0) && ((e.dest == s1) || (s2_used && (e.dest == s2)));
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (advance) begin
      ent[0] <= '{v: push, dest: push_dest};
      for (int i = 1; i < DEPTH; i++) ent[i] <= ent[i-1];
    end
  end

  always_comb begin
    pend = hit(held, rs, rt, rt_src);
    if (LOAD_LAT > 1) begin
      for (int i = 0; i < DEPTH; i++) pend = pend | hit(ent[i], rs, rt, rt_src);
    end
  end

  assign hazard = req & pend;

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered decode stage: splits an instruction into opcode/rd/rs/rt/imm and stalls on load-use hazards.
// Latency 1 cycle from in_fire to out_valid; output register held while out_valid & ~out_ready.
// Backpressure: in_ready drops on downstream stall, hazard or flush; a hazard inserts bubbles.
// Ports: clock, reset (sync, active-high), bus (slave): flush, in_valid/in_ready/in_insn,
// out_valid/out_ready, out_opcode/out_rd/out_rs/out_rt/out_imm/out_is_load, hazard.
module decode_stage_pipe
  import decode_stage_pipe_pkg::*;
#(
  parameter int INSN_W   = INSN_W_DEF,
  parameter int IMM_W    = IMM_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF
) (
  input logic           clock,
  input logic           reset,
  decode_stage_pipe_if.slave bus
);

  opc_t              dec_opcode;
  reg_t              dec_rd;
  reg_t              dec_rs;
  reg_t              dec_rt_field;
  reg_t              dec_rt;
  logic              dec_rt_src;
  logic [DATA_W-1:0] dec_imm;

  logic              valid_q;
  opc_t              opcode_q;
  reg_t              rd_q;
  reg_t              rs_q;
  reg_t              rt_q;
  logic [DATA_W-1:0] imm_q;
  logic              is_load_q;

  logic              hazard;
  logic              in_ready;
  logic              in_fire;

  assign dec_opcode   = bus.in_insn[INSN_W-1 -: OPC_W];
  assign dec_rd       = bus.in_insn[INSN_W-1-RD_OFS -: REG_W];
  assign dec_rs       = bus.in_insn[INSN_W-1-RS_OFS -: REG_W];
  assign dec_rt_field = bus.in_insn[INSN_W-1-RT_OFS -: REG_W];
  assign dec_rt       = rt_from_rd(dec_opcode) ? dec_rd : dec_rt_field;
  assign dec_rt_src   = src_rt(dec_opcode);
  assign dec_imm      = {{(DATA_W-IMM_W){bus.in_insn[IMM_W-1]}}, bus.in_insn[IMM_W-1:0]};

  assign in_ready = (~valid_q | bus.out_ready) & ~hazard & ~bus.flush;
  assign in_fire  = bus.in_valid & in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      imm_q     <= '0;
      is_load_q <= 1'b0;
    end else begin
      if (bus.flush)          valid_q <= 1'b0;
      else if (in_fire)       valid_q <= 1'b1;
      else if (bus.out_ready) valid_q <= 1'b0;
      if (in_fire) begin
        opcode_q  <= dec_opcode;
        rd_q      <= dec_rd;
        rs_q      <= dec_rs;
        rt_q      <= dec_rt;
        imm_q     <= dec_imm;
        is_load_q <= (dec_opcode == OP_LW);
      end
    end
  end

  // A flushed load never issued, so it must not occupy a scoreboard slot.
  load_scoreboard #(.LOAD_LAT(LOAD_LAT)) u_sb (
    .clock     (clock),
    .reset     (reset),
    .advance   (bus.out_ready),
    .push      (valid_q & is_load_q & ~bus.flush),
    .push_dest (rd_q),
    .held      ('{v: valid_q & is_load_q, dest: rd_q}),
    .req       (bus.in_valid),
    .rs        (dec_rs),
    .rt        (dec_rt),
    .rt_src    (dec_rt_src),
    .hazard    (hazard)
  );

  assign bus.in_ready    = in_ready;
  assign bus.hazard      = hazard;
  assign bus.out_valid   = valid_q;
  assign bus.out_opcode  = opcode_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_rs      = rs_q;
  assign bus.out_rt      = rt_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_is_load = is_load_q;

endmodule
